itrx_aib_phy_rx_edge_train_ctrl: RTL

Training controller for the AIB RX half-cycle retiming path. It drives the posedge/negedge capture select (the negedge path is built from the negedge-clock async-clear DFF cell) and sequences a training run. Each run tests both capture phases against a toggling checkerboard pattern, counts errors per phase, and locks the select onto a clean phase. It sits beside the RX retiming mux in the PHY channel and is controlled by the channel config/adapter logic.

---
 rtl/itrx_aib_phy_rx_edge_train_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/itrx_aib_phy_rx_edge_train_ctrl.sv
// AIB RX half-cycle retiming training controller: checks posedge and negedge capture
// against a toggling checkerboard, counts errors per phase and locks onto a clean phase.
module itrx_aib_phy_rx_edge_train_ctrl #(
    parameter int unsigned  W          = 8,
    parameter logic [W-1:0] PATTERN    = 8'hA5,
    parameter int unsigned  SETTLE_CYC = 4,
    parameter int unsigned  WIN_LEN    = 64,
    parameter int unsigned  ERRW       = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            train_start,
    input  logic [W-1:0]    rx_data,
    input  logic            ovrd_en,
    input  logic            ovrd_sel,
    output logic            sel_neg,
    output logic            train_busy,
    output logic            train_done,
    output logic            train_fail,
    output logic [ERRW-1:0] err_cnt_pos,
    output logic [ERRW-1:0] err_cnt_neg
);

    localparam int unsigned CYC_MAX = (WIN_LEN > SETTLE_CYC) ? WIN_LEN : SETTLE_CYC;
    localparam int unsigned CYCW    = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYCW-1:0] SETTLE_LD = CYCW'(SETTLE_CYC - 1);
    localparam logic [CYCW-1:0] WIN_LD    = CYCW'(WIN_LEN - 1);

    typedef enum logic [2:0] {
        StIdle, StSettle0, StCheck0, StSettle1, StCheck1, StEval, StDone, StFail
    } state_e;

    state_e          state_q;
    logic            sel_q;
    logic [CYCW-1:0] cyc_q;
    logic [W-1:0]    prev_q;
    logic            busy_q, done_q, fail_q;
    logic [ERRW-1:0] err_pos_q, err_neg_q;
    logic            pat_err;

    // A clean link must show PATTERN or its complement and must change every cycle.
    always_comb begin
        pat_err = ((rx_data != PATTERN) && (rx_data != ~PATTERN)) || (rx_data == prev_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            cyc_q     <= '0;
            prev_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            err_pos_q <= '0;
            err_neg_q <= '0;
        end else begin
            prev_q <= rx_data;
            unique case (state_q)
                StIdle, StDone, StFail: begin
                    if (train_start) begin
                        state_q   <= StSettle0;
                        sel_q     <= 1'b0;
                        err_pos_q <= '0;
                        err_neg_q <= '0;
                        cyc_q     <= SETTLE_LD;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        fail_q    <= 1'b0;
                    end
                end
                StSettle0: begin
                    if (cyc_q == '0) begin
                        state_q <= StCheck0;
                        cyc_q   <= WIN_LD;
                    end else begin
                        cyc_q <= cyc_q - CYCW'(1);
                    end
                end
                StCheck0: begin
                    if (pat_err && (err_pos_q != '1)) err_pos_q <= err_pos_q + ERRW'(1);
                    if (cyc_q == '0) begin
                        state_q <= StSettle1;
                        sel_q   <= 1'b1;
                        cyc_q   <= SETTLE_LD;
                    end else begin
                        cyc_q <= cyc_q - CYCW'(1);
                    end
                end
                StSettle1: begin
                    if (cyc_q == '0) begin
                        state_q <= StCheck1;
                        cyc_q   <= WIN_LD;
                    end else begin
                        cyc_q <= cyc_q - CYCW'(1);
                    end
                end
                StCheck1: begin
                    if (pat_err && (err_neg_q != '1)) err_neg_q <= err_neg_q + ERRW'(1);
                    if (cyc_q == '0) begin
                        state_q <= StEval;
                    end else begin
                        cyc_q <= cyc_q - CYCW'(1);
                    end
                end
                StEval: begin
                    busy_q <= 1'b0;
                    if (err_pos_q == '0) begin
                        sel_q   <= 1'b0;
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (err_neg_q == '0) begin
                        sel_q   <= 1'b1;
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        // Neither phase is clean: park on the lesser evil, posedge on a tie.
                        sel_q   <= (err_neg_q < err_pos_q);
                        state_q <= StFail;
                        fail_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sel_neg     = ovrd_en ? ovrd_sel : sel_q;
    assign train_busy  = busy_q;
    assign train_done  = done_q;
    assign train_fail  = fail_q;
    assign err_cnt_pos = err_pos_q;
    assign err_cnt_neg = err_neg_q;

endmodule
